// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory: load/store size encodings,
// fault codes and a small legality helper.
package data_mem_pkg;

    // Funct3 access size/sign encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Fault codes, listed in increasing priority
    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10,
        FC_ILLEGAL  = 2'b11
    } fault_code_e;

    // True for the five encodings the memory understands
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bundle between the datapath and the data memory.
// Request semantics: a request is present in any cycle where MemRead or
// MemWrite is high; there is no back-pressure, so every request is taken
// in the cycle it is presented. Loads answer combinationally in that same
// cycle, stores commit on the following rising edge unless Fault is high.
interface data_mem_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      Address;
    logic [31:0]      WriteData;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       Funct3;
    logic             ClrFault;
    logic [31:0]      ReadData;
    logic             Fault;
    logic             FaultSticky;
    logic [1:0]       FaultCode;
    logic [CNT_W-1:0] LoadCount;
    logic [CNT_W-1:0] StoreCount;

    modport master (
        output Address, WriteData, MemRead, MemWrite, Funct3, ClrFault,
        input  ReadData, Fault, FaultSticky, FaultCode, LoadCount, StoreCount
    );

    modport slave (
        input  Address, WriteData, MemRead, MemWrite, Funct3, ClrFault,
        output ReadData, Fault, FaultSticky, FaultCode, LoadCount, StoreCount
    );
endinterface

// File: rtl/data_mem_align.sv
// Byte-lane steering for the data memory: store byte enables and lane
// replication, and load lane extraction with sign/zero extension.
module data_mem_align
    import data_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Store side: replicate the source bytes into every lane so the enable alone picks the target
    always_comb begin
        byte_en    = 4'b0000;
        store_word = store_data;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << lane;
                store_word = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_en    = 4'b0011 << {lane[1], 1'b0};
                store_word = {2{store_data[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend
    always_comb begin
        shifted   = mem_word >> {lane, 3'b000};
        load_data = 32'd0;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data = mem_word;
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Single-cycle data memory: word array with asynchronous clear, fault
// classification, sticky fault capture and saturating access counters.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    data_mem_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             out_of_range;
    logic             misaligned;
    logic             illegal;
    fault_code_e      fcode;
    logic             load_fire;
    logic             store_fire;
    logic [3:0]       byte_en;
    logic [31:0]      store_word;
    logic [31:0]      load_data;
    logic [31:0]      mem_word;
    logic             sticky_q;
    logic [1:0]       code_q;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] store_cnt;

    assign word_idx     = bus.Address[IDX_W+1:2];
    // Any set bit above the index field means the word is past the array; no wrap
    assign out_of_range = |bus.Address[31:IDX_W+2];
    assign mem_word     = mem[word_idx];

    // Classify the current request; the highest-priority fault wins
    always_comb begin
        misaligned = ((bus.Funct3[1:0] == 2'b01) && bus.Address[0]) ||
                     ((bus.Funct3[1:0] == 2'b10) && (bus.Address[1:0] != 2'b00));
        illegal    = (bus.MemRead && bus.MemWrite) || !f3_legal(bus.Funct3) ||
                     (bus.MemWrite && bus.Funct3[2]);
        fcode      = FC_NONE;
        if (bus.MemRead || bus.MemWrite) begin
            if (illegal)           fcode = FC_ILLEGAL;
            else if (out_of_range) fcode = FC_RANGE;
            else if (misaligned)   fcode = FC_MISALIGN;
        end
    end

    assign bus.Fault = (fcode != FC_NONE);
    assign load_fire  = bus.MemRead && !bus.Fault;
    assign store_fire = bus.MemWrite && !bus.Fault;

    data_mem_align u_align (
        .funct3     (bus.Funct3),
        .lane       (bus.Address[1:0]),
        .store_data (bus.WriteData),
        .mem_word   (mem_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data)
    );

    // Read data is the pre-edge array contents, forced to zero unless a clean load
    assign bus.ReadData = load_fire ? load_data : 32'd0;

    // Array: cleared in reset, byte-enabled write on a clean store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else if (store_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
            end
        end
    end

    // Sticky fault: a new fault beats a same-cycle clear; code holds the first fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            code_q   <= FC_NONE;
        end else if (bus.Fault) begin
            sticky_q <= 1'b1;
            if (!sticky_q || bus.ClrFault) code_q <= fcode;
        end else if (bus.ClrFault) begin
            sticky_q <= 1'b0;
            code_q   <= FC_NONE;
        end
    end

    // Saturating counters of completed loads and stores
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (load_fire && (load_cnt != '1))   load_cnt  <= load_cnt + 1'b1;
            if (store_fire && (store_cnt != '1)) store_cnt <= store_cnt + 1'b1;
        end
    end

    assign bus.FaultSticky = sticky_q;
    assign bus.FaultCode   = code_q;
    assign bus.LoadCount   = load_cnt;
    assign bus.StoreCount  = store_cnt;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed scenarios plus randomized traffic checked
// against a byte-addressed reference model of the memory.
module tb_data_mem;
    import data_mem_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    data_mem_if #(.CNT_W(16)) bus ();
    data_mem_if #(.CNT_W(4))  bus4 ();

    data_mem #(.DEPTH_WORDS(256), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    data_mem #(.DEPTH_WORDS(16), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // ---------------- reference model ----------------
    logic [7:0]  m_mem [0:1023];
    int          m_loads;
    int          m_stores;
    logic        m_sticky;
    logic [1:0]  m_code;

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
        m_loads  = 0;
        m_stores = 0;
        m_sticky = 1'b0;
        m_code   = 2'b00;
    endtask

    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] m_fault(input logic rd, input logic wr,
                                           input logic [2:0] f3, input logic [31:0] addr);
        if (!rd && !wr) return 2'b00;
        if (rd && wr) return 2'b11;
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 2'b11;
        if (wr && f3 >= 3'd4) return 2'b11;
        if ((addr / 4) >= 256) return 2'b10;
        if ((addr % m_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        int sz;
        sz = m_size(f3);
        v  = 32'd0;
        for (int k = 0; k < sz; k++) v = v | (32'(m_mem[addr + k]) << (8 * k));
        if (f3 == 3'd0 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
        if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_step(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic clr);
        logic [1:0] c;
        c = m_fault(rd, wr, f3, addr);
        if (c != 2'b00) begin
            if (!m_sticky || clr) m_code = c;
            m_sticky = 1'b1;
        end else if (clr) begin
            m_sticky = 1'b0;
            m_code   = 2'b00;
        end
        if (c == 2'b00 && wr) begin
            for (int k = 0; k < m_size(f3); k++) m_mem[addr + k] = wdata[8*k +: 8];
            if (m_stores < 65535) m_stores++;
        end
        if (c == 2'b00 && rd && m_loads < 65535) m_loads++;
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Funct3 = 3'd2;
        bus.Address = 32'd0; bus.WriteData = 32'd0; bus.ClrFault = 1'b0;
    endtask

    // One request cycle: drive after the falling edge, sample combinational
    // outputs before the rising edge, then advance the model past the edge.
    task automatic drive_cycle(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic clr,
                               output logic obs_fault, output logic [31:0] obs_rdata);
        @(negedge clk);
        bus.MemRead = rd; bus.MemWrite = wr; bus.Funct3 = f3;
        bus.Address = addr; bus.WriteData = wdata; bus.ClrFault = clr;
        #1;
        obs_fault = bus.Fault;
        obs_rdata = bus.ReadData;
        @(posedge clk);
        model_step(rd, wr, f3, addr, wdata, clr);
        #1;
        drive_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus4.MemRead = 1'b0; bus4.MemWrite = 1'b0; bus4.Funct3 = 3'd2;
        bus4.Address = 32'd0; bus4.WriteData = 32'd0; bus4.ClrFault = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.MemRead = 1'b1; bus.Funct3 = F3_LW; bus.Address = 32'h10;
        #1;
        total_cnt++; if (bus.ReadData !== 32'd0) $display("FAIL reset_rdata got=%h exp=%h", bus.ReadData, 32'd0); else pass_cnt++;
        total_cnt++; if (bus.Fault !== 1'b0) $display("FAIL reset_fault_clean got=%b exp=0", bus.Fault); else pass_cnt++;
        bus.Address = 32'h11;
        #1;
        total_cnt++; if (bus.Fault !== 1'b1) $display("FAIL reset_fault_follows got=%b exp=1", bus.Fault); else pass_cnt++;
        total_cnt++;
        if ({bus.FaultSticky, bus.FaultCode, bus.LoadCount, bus.StoreCount} !== 35'd0)
            $display("FAIL reset_regs got=%b/%b/%h/%h exp=0", bus.FaultSticky, bus.FaultCode, bus.LoadCount, bus.StoreCount);
        else pass_cnt++;
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        logic f;
        logic [31:0] rd;
        drive_cycle(1'b0, 1'b1, F3_LW, 32'h10, 32'hDEADBEEF, 1'b0, f, rd);
        drive_cycle(1'b1, 1'b0, F3_LW, 32'h10, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_0x10 got=%h exp=%h", rd, 32'hDEADBEEF); else pass_cnt++;
        total_cnt++;
        if (bus.StoreCount !== 16'd1 || bus.LoadCount !== 16'd1)
            $display("FAIL counts_after_sw_lw got=%0d/%0d exp=1/1", bus.StoreCount, bus.LoadCount);
        else pass_cnt++;
        drive_cycle(1'b0, 1'b1, F3_LB, 32'h13, 32'h7F, 1'b0, f, rd);
        drive_cycle(1'b1, 1'b0, F3_LB, 32'h13, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'h0000007F) $display("FAIL lb_0x13 got=%h exp=%h", rd, 32'h7F); else pass_cnt++;
        drive_cycle(1'b0, 1'b1, F3_LB, 32'h12, 32'h80, 1'b0, f, rd);
        drive_cycle(1'b1, 1'b0, F3_LB, 32'h12, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_0x12 got=%h exp=%h", rd, 32'hFFFFFF80); else pass_cnt++;
        drive_cycle(1'b1, 1'b0, F3_LBU, 32'h12, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'h00000080) $display("FAIL lbu_0x12 got=%h exp=%h", rd, 32'h80); else pass_cnt++;
        drive_cycle(1'b1, 1'b0, F3_LH, 32'h12, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'h00007F80) $display("FAIL lh_0x12 got=%h exp=%h", rd, 32'h7F80); else pass_cnt++;
        drive_cycle(1'b1, 1'b0, F3_LW, 32'h10, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'h7F80BEEF) $display("FAIL lw_lanes_kept got=%h exp=%h", rd, 32'h7F80BEEF); else pass_cnt++;
    endtask

    task automatic test_faults();
        logic f;
        logic [31:0] rd;
        drive_cycle(1'b1, 1'b0, F3_LW, 32'h11, 32'd0, 1'b0, f, rd);
        total_cnt++; if (f !== 1'b1 || rd !== 32'd0) $display("FAIL lw_misaligned got=%b/%h exp=1/0", f, rd); else pass_cnt++;
        total_cnt++;
        if (bus.FaultSticky !== 1'b1 || bus.FaultCode !== 2'b01)
            $display("FAIL sticky_misaligned got=%b/%b exp=1/01", bus.FaultSticky, bus.FaultCode);
        else pass_cnt++;
        drive_cycle(1'b0, 1'b1, F3_LW, 32'h400, 32'h55AA55AA, 1'b0, f, rd);
        total_cnt++; if (f !== 1'b1) $display("FAIL sw_range_fault got=%b exp=1", f); else pass_cnt++;
        total_cnt++;
        if (bus.FaultCode !== 2'b01 || bus.StoreCount !== 16'd3)
            $display("FAIL range_keeps_code got=%b/%0d exp=01/3", bus.FaultCode, bus.StoreCount);
        else pass_cnt++;
        // idle cycle with junk on the bus must not fault; also clears sticky
        drive_cycle(1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'd0, 1'b1, f, rd);
        total_cnt++; if (f !== 1'b0 || rd !== 32'd0) $display("FAIL idle_no_fault got=%b/%h exp=0/0", f, rd); else pass_cnt++;
        total_cnt++;
        if (bus.FaultSticky !== 1'b0 || bus.FaultCode !== 2'b00)
            $display("FAIL clr_fault got=%b/%b exp=0/00", bus.FaultSticky, bus.FaultCode);
        else pass_cnt++;
        drive_cycle(1'b0, 1'b1, F3_LW, 32'h20, 32'hCAFEF00D, 1'b0, f, rd);
        drive_cycle(1'b1, 1'b1, F3_LW, 32'h20, 32'h11111111, 1'b0, f, rd);
        total_cnt++; if (f !== 1'b1 || rd !== 32'd0) $display("FAIL rd_wr_illegal got=%b/%h exp=1/0", f, rd); else pass_cnt++;
        total_cnt++; if (bus.FaultCode !== 2'b11) $display("FAIL code_illegal got=%b exp=11", bus.FaultCode); else pass_cnt++;
        drive_cycle(1'b1, 1'b0, F3_LW, 32'h20, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'hCAFEF00D) $display("FAIL word_0x20_kept got=%h exp=%h", rd, 32'hCAFEF00D); else pass_cnt++;
        drive_cycle(1'b1, 1'b0, F3_LH, 32'h21, 32'd0, 1'b1, f, rd);
        total_cnt++;
        if (bus.FaultSticky !== 1'b1 || bus.FaultCode !== 2'b01)
            $display("FAIL clr_vs_fault got=%b/%b exp=1/01", bus.FaultSticky, bus.FaultCode);
        else pass_cnt++;
        drive_cycle(1'b0, 1'b1, F3_LBU, 32'h20, 32'd0, 1'b1, f, rd);
        total_cnt++; if (f !== 1'b1 || bus.FaultCode !== 2'b11) $display("FAIL store_unsigned_illegal got=%b/%b exp=1/11", f, bus.FaultCode); else pass_cnt++;
    endtask

    task automatic test_same_cycle_rw();
        logic f;
        logic [31:0] rd;
        // a load following a store sees the new data; the store cycle itself has no read port
        drive_cycle(1'b0, 1'b1, F3_LH, 32'h32, 32'hBEEF1234, 1'b0, f, rd);
        drive_cycle(1'b1, 1'b0, F3_LHU, 32'h32, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'h00001234) $display("FAIL lhu_upper_half got=%h exp=%h", rd, 32'h1234); else pass_cnt++;
        drive_cycle(1'b1, 1'b0, F3_LW, 32'h30, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'h12340000) $display("FAIL sh_lanes got=%h exp=%h", rd, 32'h12340000); else pass_cnt++;
    endtask

    task automatic test_random();
        logic        f, rd, wr, clr;
        logic [31:0] obs_rd, addr, wdata, exp_rd;
        logic [2:0]  f3;
        logic [1:0]  exp_c;
        logic [2:0]  legal_tab [5];
        legal_tab[0] = 3'd0; legal_tab[1] = 3'd1; legal_tab[2] = 3'd2;
        legal_tab[3] = 3'd4; legal_tab[4] = 3'd5;
        for (int i = 0; i < 400; i++) begin
            int op;
            op   = $urandom_range(0, 9);
            rd   = (op <= 3) || (op == 8);
            wr   = (op >= 4 && op <= 8);
            f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal_tab[$urandom_range(0, 4)];
            if (wr && !rd && f3[2]) f3 = {1'b0, f3[1:0]};
            addr = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
            wdata = $urandom();
            clr  = ($urandom_range(0, 15) == 0);
            exp_c  = m_fault(rd, wr, f3, addr);
            exp_rd = (rd && exp_c == 2'b00) ? m_load(f3, addr) : 32'd0;
            drive_cycle(rd, wr, f3, addr, wdata, clr, f, obs_rd);
            total_cnt++; if (f !== (exp_c != 2'b00)) $display("FAIL rand_fault i=%0d got=%b exp=%b", i, f, exp_c != 2'b00); else pass_cnt++;
            total_cnt++; if (obs_rd !== exp_rd) $display("FAIL rand_rdata i=%0d got=%h exp=%h", i, obs_rd, exp_rd); else pass_cnt++;
            total_cnt++;
            if ({bus.FaultSticky, bus.FaultCode, bus.LoadCount, bus.StoreCount} !==
                {m_sticky, m_code, 16'(m_loads), 16'(m_stores)})
                $display("FAIL rand_regs i=%0d got=%b/%b/%0d/%0d exp=%b/%b/%0d/%0d", i,
                         bus.FaultSticky, bus.FaultCode, bus.LoadCount, bus.StoreCount,
                         m_sticky, m_code, m_loads, m_stores);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_store();
        logic f;
        logic [31:0] rd;
        @(negedge clk);
        bus.MemWrite = 1'b1; bus.Funct3 = F3_LW; bus.Address = 32'h40; bus.WriteData = 32'h12345678;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        drive_idle();
        model_reset();
        total_cnt++;
        if ({bus.FaultSticky, bus.FaultCode, bus.LoadCount, bus.StoreCount} !== 35'd0)
            $display("FAIL midreset_regs got=%b/%b/%0d/%0d exp=0", bus.FaultSticky, bus.FaultCode, bus.LoadCount, bus.StoreCount);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0, F3_LW, 32'h40, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'd0) $display("FAIL midreset_lw got=%h exp=0", rd); else pass_cnt++;
        drive_cycle(1'b1, 1'b0, F3_LW, 32'h10, 32'd0, 1'b0, f, rd);
        total_cnt++; if (rd !== 32'd0) $display("FAIL reset_cleared_0x10 got=%h exp=0", rd); else pass_cnt++;
        total_cnt++; if (bus.LoadCount !== 16'd2 || bus.StoreCount !== 16'd0) $display("FAIL counts_post_reset got=%0d/%0d exp=2/0", bus.LoadCount, bus.StoreCount); else pass_cnt++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus4.MemWrite = 1'b1; bus4.Funct3 = F3_LW;
            bus4.Address = 32'((i % 16) * 4); bus4.WriteData = $urandom();
            @(posedge clk);
            #1;
            if (i == 13) begin
                total_cnt++; if (bus4.StoreCount !== 4'hE) $display("FAIL sat_before got=%h exp=e", bus4.StoreCount); else pass_cnt++;
            end
        end
        bus4.MemWrite = 1'b0;
        total_cnt++; if (bus4.StoreCount !== 4'hF) $display("FAIL sat_store_count got=%h exp=f", bus4.StoreCount); else pass_cnt++;
        total_cnt++; if (bus4.LoadCount !== 4'h0) $display("FAIL sat_load_count got=%h exp=0", bus4.LoadCount); else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_store_load();
        test_faults();
        test_same_cycle_rw();
        test_random();
        test_reset_mid_store();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
